// File: rtl/systolic_mm_engine_if.sv
// Job, beat and result-row signals of the systolic matrix-multiply engine.
// master: job/beat producer and result consumer; slave: the engine.
interface systolic_mm_engine_if #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24,
    parameter int K_WIDTH      = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                          start;
    logic [K_WIDTH-1:0]            k_len;
    logic                          busy;
    logic [ROWS*DATA_WIDTH-1:0]    act_in;
    logic [COLS*WEIGHT_WIDTH-1:0]  wgt_in;
    logic                          in_valid;
    logic                          in_ready;
    logic [COLS*ACC_WIDTH-1:0]     res_out;
    logic [RW-1:0]                 res_row;
    logic                          res_valid;
    logic                          res_ready;
    logic                          done;
    logic                          sat_flag;

    modport master (
        output start, k_len, act_in, wgt_in, in_valid, res_ready,
        input  busy, in_ready, res_out, res_row, res_valid, done,
               sat_flag
    );

    modport slave (
        input  start, k_len, act_in, wgt_in, in_valid, res_ready,
        output busy, in_ready, res_out, res_row, res_valid, done,
               sat_flag
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matmul with input skew and drain.
// Ports: clk, rst_n (sync, active low), bus (slave: job/beat/result).
module systolic_mm_engine #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24,
    parameter int K_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_mm_engine_if.slave  bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = $clog2(ROWS + COLS);
    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int SW = ACC_WIDTH + 1;
    localparam int AW = ACC_WIDTH;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [K_WIDTH-1:0]   k_len_q, beat_cnt;
    logic [FW-1:0]        flush_cnt;
    logic [RW-1:0]        drain_cnt;
    logic                 job_start, feed_v, flush_end;
    logic                 row_take, load_first;
    logic                 any_sat;
    logic [ROWS*COLS-1:0] sat_ev;

    logic [COLS*AW-1:0]   res_q;
    logic [RW-1:0]        row_q;
    logic                 rv_q, done_q, sat_q;

    logic signed [DATA_WIDTH-1:0]   a_h  [ROWS][COLS];
    logic                           av_h [ROWS][COLS];
    logic signed [WEIGHT_WIDTH-1:0] w_h  [ROWS][COLS];
    logic                           wv_h [ROWS][COLS];
    logic [COLS*AW-1:0]             acc_row [ROWS];

    always_comb begin
        state_d   = state_q;
        job_start = 1'b0;
        feed_v    = 1'b0;
        flush_end = 1'b0;
        row_take  = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                job_start = 1'b1;
                state_d   = (bus.k_len != '0) ? FEED : DRAIN;
            end
            FEED: begin
                feed_v = bus.in_valid;
                if (bus.in_valid &&
                    beat_cnt == k_len_q - K_WIDTH'(1))
                    state_d = FLUSH;
            end
            FLUSH: if (flush_cnt == FLUSH_LAST) begin
                flush_end = 1'b1;
                state_d   = DRAIN;
            end
            DRAIN: if (bus.res_ready) begin
                row_take = 1'b1;
                if (drain_cnt == ROW_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A zero-length job enters DRAIN straight from IDLE with cleared sums.
    assign load_first = flush_end || (job_start && bus.k_len == '0);
    assign any_sat    = |sat_ev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_len_q   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            drain_cnt <= '0;
            res_q     <= '0;
            row_q     <= '0;
            rv_q      <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (job_start) begin
                k_len_q   <= bus.k_len;
                beat_cnt  <= '0;
                flush_cnt <= '0;
                drain_cnt <= '0;
                sat_q     <= 1'b0;
            end else if (any_sat) begin
                sat_q <= 1'b1;
            end
            if (feed_v) beat_cnt <= beat_cnt + K_WIDTH'(1);
            if (state_q == FLUSH) flush_cnt <= flush_cnt + FW'(1);
            if (load_first) begin
                rv_q  <= 1'b1;
                row_q <= '0;
                res_q <= job_start ? '0 : acc_row[0];
            end
            if (row_take) begin
                if (drain_cnt == ROW_LAST) begin
                    rv_q   <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + RW'(1);
                    row_q     <= drain_cnt + RW'(1);
                    res_q     <= acc_row[drain_cnt + RW'(1)];
                end
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = (state_q == FEED);
    assign bus.res_out   = res_q;
    assign bus.res_row   = row_q;
    assign bus.res_valid = rv_q;
    assign bus.done      = done_q;
    assign bus.sat_flag  = sat_q;

    // Lane r of activations (column c of weights) is delayed r (c) cycles
    // so beat k meets itself at PE[r][c] on cycle k+r+c.
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        if (r == 0) begin : g_pass
            assign a_h[0][0]  = bus.act_in[0 +: DATA_WIDTH];
            assign av_h[0][0] = feed_v;
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] sr [r];
            logic                  vr [r];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) begin
                        sr[i] <= '0;
                        vr[i] <= 1'b0;
                    end
                end else begin
                    sr[0] <= bus.act_in[r*DATA_WIDTH +: DATA_WIDTH];
                    vr[0] <= feed_v;
                    for (int i = 1; i < r; i++) begin
                        sr[i] <= sr[i-1];
                        vr[i] <= vr[i-1];
                    end
                end
            end
            assign a_h[r][0]  = sr[r-1];
            assign av_h[r][0] = vr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wskew
        if (c == 0) begin : g_pass
            assign w_h[0][0]  = bus.wgt_in[0 +: WEIGHT_WIDTH];
            assign wv_h[0][0] = feed_v;
        end else begin : g_dly
            logic [WEIGHT_WIDTH-1:0] sr [c];
            logic                    vr [c];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) begin
                        sr[i] <= '0;
                        vr[i] <= 1'b0;
                    end
                end else begin
                    sr[0] <= bus.wgt_in[c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                    vr[0] <= feed_v;
                    for (int i = 1; i < c; i++) begin
                        sr[i] <= sr[i-1];
                        vr[i] <= vr[i-1];
                    end
                end
            end
            assign w_h[0][c]  = sr[c-1];
            assign wv_h[0][c] = vr[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            logic signed [AW-1:0] acc_q, acc_n;
            logic signed [PW-1:0] prod;
            logic signed [SW-1:0] sum;
            logic                 ovf, hit;

            assign prod = PW'(a_h[r][c]) * PW'(w_h[r][c]);
            assign sum  = SW'(acc_q) + SW'(prod);
            // One guard bit: overflow when it disagrees with the sign bit.
            assign ovf  = sum[SW-1] ^ sum[SW-2];
            assign acc_n = !ovf ? sum[AW-1:0] :
                           sum[SW-1] ? {1'b1, {(AW-1){1'b0}}}
                                     : {1'b0, {(AW-1){1'b1}}};
            assign hit = av_h[r][c] & wv_h[r][c];
            assign sat_ev[r*COLS + c] = hit & ovf;
            assign acc_row[r][c*AW +: AW] = acc_q;

            always_ff @(posedge clk) begin
                if (!rst_n)         acc_q <= '0;
                else if (job_start) acc_q <= '0;
                else if (hit)       acc_q <= acc_n;
            end

            if (c < COLS - 1) begin : g_right
                logic signed [DATA_WIDTH-1:0] a_q;
                logic                         av_q;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        a_q  <= '0;
                        av_q <= 1'b0;
                    end else begin
                        a_q  <= a_h[r][c];
                        av_q <= av_h[r][c];
                    end
                end
                assign a_h[r][c+1]  = a_q;
                assign av_h[r][c+1] = av_q;
            end

            if (r < ROWS - 1) begin : g_down
                logic signed [WEIGHT_WIDTH-1:0] w_q;
                logic                           wv_q;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        w_q  <= '0;
                        wv_q <= 1'b0;
                    end else begin
                        w_q  <= w_h[r][c];
                        wv_q <= wv_h[r][c];
                    end
                end
                assign w_h[r+1][c]  = w_q;
                assign wv_h[r+1][c] = wv_q;
            end
        end
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: table of jobs plus
// hand-written reset-abort sequence.
module tb_systolic_mm_engine;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int NJ   = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    systolic_mm_engine_if #(
        .ROWS(4), .COLS(4), .DATA_WIDTH(16),
        .WEIGHT_WIDTH(8), .ACC_WIDTH(24), .K_WIDTH(8)
    ) bus ();

    systolic_mm_engine #(
        .ROWS(4), .COLS(4), .DATA_WIDTH(16),
        .WEIGHT_WIDTH(8), .ACC_WIDTH(24), .K_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int               k;
        logic [63:0]      act;
        logic [31:0]      wgt;
        logic [3:0][95:0] exp;
        logic             sat;
        bit               bubble;
        bit               stall;
        bit               poke;
    } vec_t;

    vec_t tbl [NJ];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [95:0] got,
                       input logic [95:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic set_vec(input int i, input int k,
                           input logic [63:0] act,
                           input logic [31:0] wgt,
                           input logic [95:0] e0, input logic [95:0] e1,
                           input logic [95:0] e2, input logic [95:0] e3,
                           input logic sat, input bit bub,
                           input bit stl, input bit pk);
        tbl[i].k      = k;
        tbl[i].act    = act;
        tbl[i].wgt    = wgt;
        tbl[i].exp[0] = e0;
        tbl[i].exp[1] = e1;
        tbl[i].exp[2] = e2;
        tbl[i].exp[3] = e3;
        tbl[i].sat    = sat;
        tbl[i].bubble = bub;
        tbl[i].stall  = stl;
        tbl[i].poke   = pk;
    endtask

    task automatic run_job(input int j);
        vec_t v;
        int   beats, cyc, n, stl;
        bit   acc_ok;
        v = tbl[j];
        bus.start = 1'b1;
        bus.k_len = 8'(v.k);
        tick();
        bus.start = 1'b0;
        chk($sformatf("j%0d sat_clr", j), 96'(bus.sat_flag), 96'(0));
        chk($sformatf("j%0d busy", j), 96'(bus.busy), 96'(1));
        beats = 0;
        cyc   = 0;
        while (beats < v.k && cyc < 200) begin
            bus.in_valid = !(v.bubble && cyc[0]);
            bus.act_in   = bus.in_valid ? v.act : 64'hFFFF_FFFF_FFFF_FFFF;
            bus.wgt_in   = bus.in_valid ? v.wgt : 32'hFFFF_FFFF;
            if (v.poke && beats == 1) begin
                bus.start = 1'b1;
                bus.k_len = 8'd1;
            end
            chk($sformatf("j%0d in_ready_feed", j),
                96'(bus.in_ready), 96'(1));
            acc_ok = bus.in_valid && bus.in_ready;
            tick();
            bus.start = 1'b0;
            if (acc_ok) beats++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.act_in   = 64'h8000_7FFF_8000_7FFF;
        bus.wgt_in   = 32'h7F80_7F80;
        if (v.k != 0) begin
            chk($sformatf("j%0d in_ready_flush", j),
                96'(bus.in_ready), 96'(0));
            chk($sformatf("j%0d busy_flush", j), 96'(bus.busy), 96'(1));
        end
        n = 0;
        while (!bus.res_valid && n < 50) begin
            tick();
            n++;
        end
        chk($sformatf("j%0d flush_len", j), 96'(n),
            96'((v.k == 0) ? 0 : ROWS + COLS - 1));
        for (int r = 0; r < ROWS; r++) begin
            stl = v.stall ? 3 : 0;
            for (int s = 0; s <= stl; s++) begin
                bus.res_ready = (s == stl);
                chk($sformatf("j%0d r%0d valid", j, r),
                    96'(bus.res_valid), 96'(1));
                chk($sformatf("j%0d r%0d row", j, r),
                    96'(bus.res_row), 96'(r));
                chk($sformatf("j%0d r%0d data", j, r),
                    bus.res_out, v.exp[r]);
                chk($sformatf("j%0d r%0d done_early", j, r),
                    96'(bus.done), 96'(0));
                tick();
            end
            bus.res_ready = 1'b0;
        end
        chk($sformatf("j%0d done", j), 96'(bus.done), 96'(1));
        chk($sformatf("j%0d valid_off", j), 96'(bus.res_valid), 96'(0));
        chk($sformatf("j%0d idle", j), 96'(bus.busy), 96'(0));
        chk($sformatf("j%0d sat", j), 96'(bus.sat_flag), 96'(v.sat));
        tick();
        chk($sformatf("j%0d done_pulse", j), 96'(bus.done), 96'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        set_vec(0, 1, {4{16'h0A00}}, {4{8'h50}},
                {4{24'h032000}}, {4{24'h032000}},
                {4{24'h032000}}, {4{24'h032000}}, 1'b0, 0, 0, 0);
        set_vec(1, 4, {16'h1000, 16'h0C00, 16'h0800, 16'h0400},
                {4{8'h40}},
                {4{24'h040000}}, {4{24'h080000}},
                {4{24'h0C0000}}, {4{24'h100000}}, 1'b0, 0, 0, 0);
        set_vec(2, 3, {4{16'h7FFF}}, {4{8'h7F}},
                {4{24'h7FFFFF}}, {4{24'h7FFFFF}},
                {4{24'h7FFFFF}}, {4{24'h7FFFFF}}, 1'b1, 0, 0, 0);
        set_vec(3, 3, {4{16'h8000}}, {4{8'h7F}},
                {4{24'h800000}}, {4{24'h800000}},
                {4{24'h800000}}, {4{24'h800000}}, 1'b1, 0, 0, 0);
        set_vec(4, 4, {16'h1000, 16'h0C00, 16'h0800, 16'h0400},
                {4{8'h40}},
                {4{24'h040000}}, {4{24'h080000}},
                {4{24'h0C0000}}, {4{24'h100000}}, 1'b0, 1, 1, 0);
        set_vec(5, 0, {4{16'h1234}}, {4{8'h11}},
                96'h0, 96'h0, 96'h0, 96'h0, 1'b0, 0, 0, 0);
        set_vec(6, 2, {4{16'h0400}}, {8'h10, 8'h20, 8'h40, 8'hC0},
                {24'h008000, 24'h010000, 24'h020000, 24'hFE0000},
                {24'h008000, 24'h010000, 24'h020000, 24'hFE0000},
                {24'h008000, 24'h010000, 24'h020000, 24'hFE0000},
                {24'h008000, 24'h010000, 24'h020000, 24'hFE0000},
                1'b0, 0, 0, 1);

        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.act_in    = '0;
        bus.wgt_in    = '0;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst busy", 96'(bus.busy), 96'(0));
        chk("rst in_ready", 96'(bus.in_ready), 96'(0));
        chk("rst res_valid", 96'(bus.res_valid), 96'(0));
        chk("rst done", 96'(bus.done), 96'(0));
        chk("rst res_out", bus.res_out, 96'(0));
        rst_n = 1'b1;
        tick();

        for (int j = 0; j < NJ; j++) begin
            run_job(j);
            tick();
        end

        // Abort a job half-way through FEED with reset.
        bus.start = 1'b1;
        bus.k_len = 8'd4;
        tick();
        bus.start    = 1'b0;
        bus.act_in   = tbl[1].act;
        bus.wgt_in   = tbl[1].wgt;
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort busy", 96'(bus.busy), 96'(0));
        chk("abort in_ready", 96'(bus.in_ready), 96'(0));
        chk("abort res_valid", 96'(bus.res_valid), 96'(0));
        chk("abort done", 96'(bus.done), 96'(0));
        chk("abort sat", 96'(bus.sat_flag), 96'(0));
        chk("abort res_out", bus.res_out, 96'(0));
        chk("abort res_row", 96'(bus.res_row), 96'(0));
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done || bus.res_valid || bus.busy) seen++;
            tick();
        end
        chk("abort quiet", 96'(seen), 96'(0));
        run_job(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
Output-stationary ROWS x COLS systolic matrix-multiply engine with built-in input skewing, job control and result drain. Computes C[r][c] = sum over k of A[r][k]*W[k][c] for a job of k_len input beats. One activation vector (ROWS lanes) and one weight vector (COLS lanes) are accepted per beat. Results leave one row per handshake. It succeeds the bare PE grid and sits between the tile-buffer/DMA layer and the accumulator writeback.

Parameters:
ROWS, 4, PE rows / activation lanes
COLS, 4, PE columns / weight lanes
DATA_WIDTH, 16, signed activation width, S5.10
WEIGHT_WIDTH, 8, signed weight width, S1.6
ACC_WIDTH, 24, signed accumulator width, S7.16; product fraction bits (10+6) equal accumulator fraction bits, so no shift
K_WIDTH, 8, width of k_len; max job depth 2^K_WIDTH-1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  job request, sampled only in IDLE
k_len  in  K_WIDTH  beats in job, captured with start
busy  out  1  high in any state except IDLE
act_in  in  ROWS*DATA_WIDTH  lane r at [r*DATA_WIDTH +: DATA_WIDTH]
wgt_in  in  COLS*WEIGHT_WIDTH  lane c at [c*WEIGHT_WIDTH +: WEIGHT_WIDTH]
in_valid  in  1  act_in/wgt_in beat valid
in_ready  out  1  engine accepts beat
res_out  out  COLS*ACC_WIDTH  row of results, column c at [c*ACC_WIDTH +: ACC_WIDTH]
res_row  out  max(1,$clog2(ROWS))  row index of res_out
res_valid  out  1  res_out valid
res_ready  in  1  consumer accepts row
done  out  1  one-cycle pulse after last row accepted
sat_flag  out  1  sticky: any accumulator saturated this job

Behaviour:
- Reset (rst_n=0 at edge): state IDLE. All outputs 0. Accumulators, skew registers, PE valid pipelines and counters are cleared. Reset mid-job aborts the job and produces no done.
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE: start=1 captures k_len. Accumulators and sat_flag clear at the same edge. Next state is FEED if k_len!=0, else DRAIN. start outside IDLE is ignored.
- FEED: in_ready=1. A beat is accepted when in_valid&in_ready. Each accepted beat increments beat_cnt. A cycle without in_valid injects a bubble: data don't-care, valid=0. On acceptance of beat k_len, go to FLUSH next cycle.
- Skew: activation lane r is delayed r cycles before PE[r][0]. Weight lane c is delayed c cycles before PE[0][c]. Data and valid bits flow right (activations) and down (weights) through one register per PE.
- PE[r][c] accumulates a*w only when both the incoming activation valid and the incoming weight valid are 1.
- Products are the full signed DATA_WIDTH+WEIGHT_WIDTH bits, sign-extended or truncated to ACC_WIDTH+1 for the add.
- Sums saturate to 0x7FFFFF or 0x800000 for the default width. Any saturation sets sat_flag, which holds until the next start.
- FLUSH: in_ready=0. Lasts exactly ROWS+COLS-1 cycles, enough for the last beat to reach PE[ROWS-1][COLS-1] and commit. Then go to DRAIN.
- DRAIN: res_valid=1, res_row=drain_cnt, res_out=accumulators of that row, registered.
- DRAIN stall: while res_valid&!res_ready, res_out and res_row stay stable.
- DRAIN advance: on handshake, drain_cnt increments. After row ROWS-1 is accepted, res_valid=0, done=1 for one cycle and state returns to IDLE.
- k_len=0 job: DRAIN emits ROWS all-zero rows, then done.
- busy=1 from the cycle after start until the cycle after done.
- sat_flag is readable after done.

Test Plan:
1. Single beat: start, k_len=1, all act lanes 0x0A00 (2.5), all wgt lanes 0x50 (1.25) -> 4 rows, every column 0x032000; done once; sat_flag=0.
2. Row-scaled: k_len=4, act lane r=(r+1)<<10, all wgt=0x40 (1.0) every beat -> row r columns all (4*(r+1))<<16; row 3 = 0x100000; res_row 0..3 in order.
3. Saturation: k_len=3, act 0x7FFF, wgt 0x7F -> all results 0x7FFFFF, sat_flag=1. Repeat with act 0x8000 -> 0x800000, sat_flag=1, and sat_flag cleared at that start.
4. Bubbles/backpressure: test 2 data with in_valid low on alternate cycles and res_ready low 3 cycles per row -> identical results to test 2; res_out stable while stalled; in_ready=0 in FLUSH.
5. Empty job and ignored start: k_len=0 -> 4 zero rows then done. start pulsed during FEED of another job -> no effect on beat count or results.
6. Reset mid-FEED after 2 of 4 beats -> next cycle busy=0, all outputs 0, no done. A subsequent test-1 job gives 0x032000 everywhere.
